// File: rtl/posit_fault_pkg.sv
// posit_fault_pkg: shared status codes, FSM states and NaR helper for the posit fault responder.
package posit_fault_pkg;

    localparam logic [1:0] CLEAN         = 2'd0;
    localparam logic [1:0] FALSE_ALARM   = 2'd1;
    localparam logic [1:0] CORRECTED     = 2'd2;
    localparam logic [1:0] UNCORRECTABLE = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

    // NaR for an n-bit posit is a 1 followed by zeros; callers take the low n bits.
    function automatic logic [63:0] nar(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb count_d = (inc && !(&count_q)) ? count_q + W'(1) : count_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else     count_q <= count_d;

    assign count = count_q;

endmodule

// File: rtl/posit_fault_responder.sv
// posit_fault_responder: re-executes faulted posit sums and majority-votes the result.
// Optional macro FAULT_TIMEOUT_EN adds a per-try recompute watchdog of TIMEOUT cycles.
module posit_fault_responder
    import posit_fault_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int MAX_TRIES = 3,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    input  logic [NBITS-1:0] in_sum,
    input  logic             in_fault,
    output logic             rc_valid,
    input  logic             rc_ready,
    output logic [NBITS-1:0] rc_a,
    output logic [NBITS-1:0] rc_b,
    input  logic             rc_done,
    input  logic [NBITS-1:0] rc_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_sum,
    output logic [1:0]       out_status,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TWO   = TW'(2);

    state_e           state_q, state_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, orig_q, orig_d, r_prev_q, r_prev_d;
    logic [NBITS-1:0] out_sum_q, out_sum_d;
    logic [1:0]       out_status_q, out_status_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             fault_inc, uncorr_inc, tmo;

`ifdef FAULT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
    always_comb begin
        tmo  = state_q == WAIT && !rc_done && wd_q == WD_LAST;
        wd_d = state_q == WAIT ? wd_q + WDW'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        orig_d       = orig_q;
        r_prev_d     = r_prev_q;
        out_sum_d    = out_sum_q;
        out_status_d = out_status_q;
        tries_d      = tries_q;
        fault_inc    = 1'b0;
        uncorr_inc   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                orig_d  = in_sum;
                tries_d = '0;
                if (in_fault) begin
                    fault_inc = 1'b1;
                    state_d   = ISSUE;
                end else begin
                    out_sum_d    = in_sum;
                    out_status_d = CLEAN;
                    state_d      = OUT;
                end
            end
            ISSUE: if (rc_ready) begin
                tries_d = tries_q + TW'(1);
                state_d = WAIT;
            end
            WAIT: if (rc_done) begin
                // Agreement with the original sum means the checker fired spuriously.
                if (rc_sum == orig_q) begin
                    out_sum_d    = orig_q;
                    out_status_d = FALSE_ALARM;
                    state_d      = OUT;
                end else if (tries_q >= TWO && rc_sum == r_prev_q) begin
                    out_sum_d    = rc_sum;
                    out_status_d = CORRECTED;
                    state_d      = OUT;
                end else if (tries_q < MAX_T) begin
                    r_prev_d = rc_sum;
                    state_d  = ISSUE;
                end else begin
                    out_sum_d    = orig_q;
                    out_status_d = UNCORRECTABLE;
                    uncorr_inc   = 1'b1;
                    state_d      = OUT;
                end
            end else if (tmo) begin
                out_sum_d    = orig_q;
                out_status_d = UNCORRECTABLE;
                uncorr_inc   = 1'b1;
                state_d      = OUT;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            orig_q       <= '0;
            r_prev_q     <= '0;
            out_sum_q    <= '0;
            out_status_q <= CLEAN;
            tries_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            orig_q       <= orig_d;
            r_prev_q     <= r_prev_d;
            out_sum_q    <= out_sum_d;
            out_status_q <= out_status_d;
            tries_q      <= tries_d;
        end

    sat_counter #(.W(CNT_W)) u_fault_cnt  (.clk(clk), .rst(rst), .inc(fault_inc),  .count(fault_cnt));
    sat_counter #(.W(CNT_W)) u_uncorr_cnt (.clk(clk), .rst(rst), .inc(uncorr_inc), .count(uncorr_cnt));

    assign in_ready   = state_q == IDLE && !rst;
    assign rc_valid   = state_q == ISSUE;
    assign rc_a       = a_q;
    assign rc_b       = b_q;
    assign out_valid  = state_q == OUT;
    assign out_sum    = out_sum_q;
    assign out_status = out_status_q;

endmodule

// File: tb/tb_posit_fault_responder.sv
// tb_posit_fault_responder: directed scoreboard bench; CNT_W=2 exposes counter saturation.
module tb_posit_fault_responder;
    import posit_fault_pkg::*;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_fault = 0, rc_ready = 0, rc_done = 0, out_ready = 1;
    logic [31:0] in_a = 0, in_b = 0, in_sum = 0, rc_sum = 0;
    logic        in_ready, rc_valid, out_valid;
    logic [31:0] rc_a, rc_b, out_sum;
    logic [1:0]  out_status, fault_cnt, uncorr_cnt;

    typedef struct packed {logic [31:0] sum; logic [1:0] st;} exp_t;
    exp_t        sb[$];
    int          total = 0, bad = 0;
    logic [31:0] cur_a, cur_b;
    logic [63:0] nar_w;

    posit_fault_responder #(.NBITS(32), .MAX_TRIES(3), .CNT_W(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_fault(in_fault),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_a(rc_a), .rc_b(rc_b),
        .rc_done(rc_done), .rc_sum(rc_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_status(out_status), .fault_cnt(fault_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, b, s, input logic f);
        int n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        check("in_ready_wait", {31'd0, in_ready}, 1);
        cur_a = a; cur_b = b;
        in_valid = 1; in_a = a; in_b = b; in_sum = s; in_fault = f;
        tick();
        in_valid = 0;
    endtask

    task automatic handshake();
        int n = 0;
        while (!rc_valid && n < 20) begin tick(); n++; end
        check("rc_valid_wait", {31'd0, rc_valid}, 1);
        check("rc_a", rc_a, cur_a);
        check("rc_b", rc_b, cur_b);
        rc_ready = 1;
        tick();
        rc_ready = 0;
    endtask

    task automatic serve(input logic [31:0] r);
        handshake();
        tick();
        rc_done = 1; rc_sum = r;
        tick();
        rc_done = 0;
    endtask

    task automatic collect();
        int n = 0;
        exp_t e = '0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("out_valid_wait", {31'd0, out_valid}, 1);
        check("sb_nonempty", sb.size(), sb.size() > 0 ? sb.size() : 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_status", {30'd0, out_status}, {30'd0, e.st});
        check("rc_idle_at_out", {31'd0, rc_valid}, 0);
        out_ready = 1;
        tick();
    endtask

    initial begin
        nar_w = nar(32);
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_rc_valid", {31'd0, rc_valid}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_status", {30'd0, out_status}, 0);
        check("rst_fault_cnt", {30'd0, fault_cnt}, 0);
        tick(); tick();
        rst = 0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 1);

        sb.push_back({32'h48000000, CLEAN});
        offer(32'h40000000, 32'h40000000, 32'h48000000, 0);
        check("clean_latency", {31'd0, out_valid}, 1);
        check("clean_no_rc", {31'd0, rc_valid}, 0);
        collect();
        check("clean_in_ready_back", {31'd0, in_ready}, 1);
        check("clean_fault_cnt", {30'd0, fault_cnt}, 0);

        sb.push_back({32'h48000000, FALSE_ALARM});
        offer(32'h40000000, 32'h40000000, 32'h48000000, 1);
        serve(32'h48000000);
        collect();
        check("fa_fault_cnt", {30'd0, fault_cnt}, 1);

        sb.push_back({32'h48000000, CORRECTED});
        offer(32'h40000000, 32'h40000000, 32'h4C000000, 1);
        serve(32'h48000000);
        serve(32'h48000000);
        collect();
        check("corr_fault_cnt", {30'd0, fault_cnt}, 2);

        sb.push_back({32'h4C000000, UNCORRECTABLE});
        offer(32'h40000000, 32'h40000000, 32'h4C000000, 1);
        serve(32'h48000000);
        serve(32'h44000000);
        serve(32'h50000000);
        collect();
        check("unc_uncorr_cnt", {30'd0, uncorr_cnt}, 1);
        check("unc_fault_cnt", {30'd0, fault_cnt}, 3);

        sb.push_back({nar_w[31:0], FALSE_ALARM});
        offer(32'h12345678, 32'h9abcdef0, nar_w[31:0], 1);
        serve(nar_w[31:0]);
        collect();
        check("sat_fault_cnt", {30'd0, fault_cnt}, 3);

        sb.push_back({nar_w[31:0], CLEAN});
        offer(32'h0, 32'h0, nar_w[31:0], 0);
        collect();

        out_ready = 0;
        sb.push_back({32'h3C000000, CLEAN});
        offer(32'h11111111, 32'h22222222, 32'h3C000000, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_out_sum", out_sum, 32'h3C000000);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            tick();
        end
        collect();

        offer(32'hAAAA0000, 32'h0000BBBB, 32'h4C000000, 1);
        handshake();
        rst = 1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_rc_valid", {31'd0, rc_valid}, 0);
        check("mid_rst_out_sum", out_sum, 0);
        check("mid_rst_fault_cnt", {30'd0, fault_cnt}, 0);
        check("mid_rst_uncorr_cnt", {30'd0, uncorr_cnt}, 0);
        tick();
        rst = 0;
        rc_done = 1; rc_sum = 32'h4C000000;
        tick();
        rc_done = 0;
        for (int i = 0; i < 3; i++) begin
            check("late_done_out_valid", {31'd0, out_valid}, 0);
            check("late_done_in_ready", {31'd0, in_ready}, 1);
            tick();
        end

`ifdef FAULT_TIMEOUT_EN
        sb.push_back({32'h4C000000, UNCORRECTABLE});
        offer(32'h40000000, 32'h40000000, 32'h4C000000, 1);
        handshake();
        for (int i = 0; i < 7; i++) tick();
        check("tmo_not_early", {31'd0, out_valid}, 0);
        tick();
        check("tmo_fires", {31'd0, out_valid}, 1);
        collect();
        check("tmo_uncorr_cnt", {30'd0, uncorr_cnt}, 1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
